// File: rtl/adc_sample_scheduler.sv
// Round-robin scheduler sharing one serial ADC reader between two requesters.
// One conversion at a time: start pulse, bounded wait for completion, tagged result.
module adc_sample_scheduler #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clock44kHz,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             adc_listo,
  input  logic [WIDTH-1:0] adc_dout,
  output logic             adc_inicio,
  output logic [WIDTH-1:0] sample,
  output logic             valid0,
  output logic             valid1,
  output logic             busy,
  output logic             grant,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("adc_sample_scheduler: TIMEOUT must be within 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               grant_n;
  logic [WIDTH-1:0]   sample_n;
  logic               inicio_n;
  logic               valid0_n;
  logic               valid1_n;
  logic               timeout_n;
  logic               busy_n;

  // State register plus registered copies of every output
  always_ff @(posedge clock44kHz or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= 1'b0;
      cnt         <= '0;
      grant       <= 1'b0;
      sample      <= '0;
      adc_inicio  <= 1'b0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      sample      <= sample_n;
      adc_inicio  <= inicio_n;
      valid0      <= valid0_n;
      valid1      <= valid1_n;
      timeout_err <= timeout_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-output logic; outputs describe the state being entered
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    grant_n   = grant;
    sample_n  = sample;
    inicio_n  = 1'b0;
    valid0_n  = 1'b0;
    valid1_n  = 1'b0;
    timeout_n = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // Lone requester wins outright; on contention the pointer decides
          grant_n  = (req0 && req1) ? ptr : req1;
          inicio_n = 1'b1;
          state_n  = S_START;
        end
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        // Completion takes precedence over the terminal count
        if (adc_listo) begin
          sample_n = adc_dout;
          valid0_n = ~grant;
          valid1_n = grant;
          ptr_n    = ~grant;
          state_n  = S_DONE;
        end else if (cnt == CNT_TERM) begin
          timeout_n = 1'b1;
          ptr_n     = ~grant;
          state_n   = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-timing reference model based on absolute clock-edge arithmetic.
module tb_adc_sample_scheduler;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic             clock44kHz = 1'b0;
  logic             reset      = 1'b0;
  logic             req0       = 1'b0;
  logic             req1       = 1'b0;
  logic             adc_listo  = 1'b0;
  logic [WIDTH-1:0] adc_dout   = '0;
  logic             adc_inicio;
  logic [WIDTH-1:0] sample;
  logic             valid0;
  logic             valid1;
  logic             busy;
  logic             grant;
  logic             timeout_err;

  always #5 clock44kHz = ~clock44kHz;

  adc_sample_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock44kHz (clock44kHz),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .adc_listo  (adc_listo),
    .adc_dout   (adc_dout),
    .adc_inicio (adc_inicio),
    .sample     (sample),
    .valid0     (valid0),
    .valid1     (valid1),
    .busy       (busy),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: e = index of the next clock edge; a conversion accepted at
  // edge a starts at a+1 and its k-th wait window is sampled at edge a+1+k.
  int               e           = 0;
  int               m_a         = 0;
  int               m_idle_from = 0;
  logic             m_conv      = 1'b0;
  logic             m_ptr       = 1'b0;
  logic             exp_inicio  = 1'b0;
  logic             exp_v0      = 1'b0;
  logic             exp_v1      = 1'b0;
  logic             exp_tout    = 1'b0;
  logic             exp_busy    = 1'b0;
  logic             exp_grant   = 1'b0;
  logic [WIDTH-1:0] exp_sample  = '0;

  // ADC reader behaviour driven by the bench
  int               cd         = -1;
  int               adc_delay  = 5;
  bit               respond    = 1'b1;
  bit               rand_delay = 1'b0;
  logic [WIDTH-1:0] adc_data   = '0;

  task automatic model_reset();
    m_idle_from = e;
    m_conv      = 1'b0;
    m_ptr       = 1'b0;
    exp_inicio  = 1'b0;
    exp_v0      = 1'b0;
    exp_v1      = 1'b0;
    exp_tout    = 1'b0;
    exp_busy    = 1'b0;
    exp_grant   = 1'b0;
    exp_sample  = '0;
    cd          = -1;
  endtask

  task automatic model_edge(input logic r0, input logic r1, input logic l,
                            input logic [WIDTH-1:0] d);
    int k;
    exp_inicio = 1'b0;
    exp_v0     = 1'b0;
    exp_v1     = 1'b0;
    exp_tout   = 1'b0;
    if (e >= m_idle_from) begin
      if (r0 || r1) begin
        exp_grant   = (r0 && r1) ? m_ptr : r1;
        m_a         = e;
        m_conv      = 1'b1;
        m_idle_from = 32'h7fff_ffff;
        exp_inicio  = 1'b1;
      end
    end else if (m_conv) begin
      k = e - m_a - 1;
      if (k >= 1) begin
        if (l) begin
          exp_sample  = d;
          exp_v0      = !exp_grant;
          exp_v1      = exp_grant;
          m_ptr       = !exp_grant;
          m_conv      = 1'b0;
          m_idle_from = e + 2;
        end else if (k == int'(TIMEOUT)) begin
          exp_tout    = 1'b1;
          m_ptr       = !exp_grant;
          m_conv      = 1'b0;
          m_idle_from = e + 1;
        end
      end
    end
    exp_busy = (e + 1 < m_idle_from);
    e++;
  endtask

  task automatic compare_all();
    check("adc_inicio",  32'(adc_inicio),  32'(exp_inicio));
    check("valid0",      32'(valid0),      32'(exp_v0));
    check("valid1",      32'(valid1),      32'(exp_v1));
    check("timeout_err", 32'(timeout_err), 32'(exp_tout));
    check("busy",        32'(busy),        32'(exp_busy));
    check("grant",       32'(grant),       32'(exp_grant));
    check("sample",      32'(sample),      32'(exp_sample));
    check("valid_excl",  32'(valid0 & valid1), 32'(0));
  endtask

  // One clock: drive inputs at the falling edge, predict, then compare next falling edge
  task automatic run_cycle(input logic r0, input logic r1, input logic spur);
    logic l;
    if (exp_inicio) cd = rand_delay ? int'($urandom_range(TIMEOUT + 1, 1)) : adc_delay;
    else if (cd > 0) cd--;
    l = spur;
    if (cd == 0) begin
      l  = l | respond;
      cd = -1;
    end
    req0      = r0;
    req1      = r1;
    adc_listo = l;
    adc_dout  = adc_data;
    model_edge(r0, r1, l, adc_data);
    @(posedge clock44kHz);
    @(negedge clock44kHz);
    compare_all();
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    adc_listo = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (n) @(negedge clock44kHz);
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    int  t_ini, t_evt, n_ini, n_val;
    bit  seen, bad;
    logic owner;
    logic r0, r1;

    @(negedge clock44kHz);
    do_reset(2);

    // Single requester, ADC answers 5 cycles after the start pulse
    adc_delay = 5; respond = 1'b1; adc_data = 4'hA;
    t_ini = -1; t_evt = -1; n_ini = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0);
      if (adc_inicio) begin n_ini++; t_ini = i; end
      if (valid0) begin seen = 1'b1; t_evt = i; end
    end
    check("r032_valid_seen", 32'(seen), 32'(1));
    check("r032_inicio_count", 32'(n_ini), 32'(1));
    check("r032_latency", 32'(t_evt - t_ini), 32'(6));
    check("r032_sample", 32'(sample), 32'(4'hA));
    check("r032_grant", 32'(grant), 32'(0));
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);

    // Both requesters streaming: ownership must alternate starting at 0
    do_reset(1);
    adc_delay = 3; adc_data = 4'h6;
    owner = 1'b0; n_val = 0; bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      run_cycle(1'b1, 1'b1, 1'b0);
      if (valid0 || valid1) begin
        if (valid1 != owner) bad = 1'b1;
        owner = !owner;
        n_val++;
      end
    end
    check("r033_alternation", 32'(bad), 32'(0));
    check("r033_enough_valids", 32'(n_val >= 4), 32'(1));
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);

    // ADC never answers: timeout, sample preserved, no valid
    do_reset(1);
    respond = 1'b0;
    t_ini = -1; t_evt = -1; seen = 1'b0;
    for (int i = 0; i < 40 && t_evt < 0; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0);
      if (adc_inicio && t_ini < 0) t_ini = i;
      if (valid1) seen = 1'b1;
      if (timeout_err) t_evt = i;
    end
    check("r034_timeout_seen", 32'(t_evt >= 0), 32'(1));
    check("r034_latency", 32'(t_evt - t_ini), 32'(TIMEOUT + 1));
    check("r034_no_valid1", 32'(seen), 32'(0));
    check("r034_sample_kept", 32'(sample), 32'(0));
    check("r034_idle", 32'(busy), 32'(0));
    run_cycle(1'b0, 1'b0, 1'b0);

    // Completion on the terminal wait cycle wins over the timeout
    respond = 1'b1; adc_delay = int'(TIMEOUT); adc_data = 4'h3;
    seen = 1'b0; bad = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0);
      if (timeout_err) bad = 1'b1;
      if (valid0) seen = 1'b1;
    end
    check("r035_valid_seen", 32'(seen), 32'(1));
    check("r035_no_timeout", 32'(bad), 32'(0));
    check("r035_sample", 32'(sample), 32'(4'h3));
    run_cycle(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a wait, then a stray completion
    respond = 1'b0; adc_data = 4'hC;
    repeat (5) run_cycle(1'b1, 1'b0, 1'b0);
    check("r036_busy_before", 32'(busy), 32'(1));
    do_reset(2);
    adc_data = 4'h7; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (valid0 || valid1 || timeout_err) seen = 1'b1;
    end
    check("r036_no_events", 32'(seen), 32'(0));
    check("r036_sample_reset", 32'(sample), 32'(0));

    // Spurious completion while idle must not disturb the captured sample
    respond = 1'b1; adc_delay = 2; adc_data = 4'h9;
    for (int i = 0; i < 10; i++) run_cycle(i < 2, 1'b0, 1'b0);
    adc_data = 4'h5;
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1);
    check("r037_sample_kept", 32'(sample), 32'(4'h9));
    check("r037_no_valid", 32'(valid0 | valid1), 32'(0));

    // Randomized traffic with variable ADC latency, spurious pulses and resets
    rand_delay = 1'b1; respond = 1'b1;
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7, 0) == 0) r0 = !r0;
      if ($urandom_range(7, 0) == 0) r1 = !r1;
      adc_data = WIDTH'($urandom);
      run_cycle(r0, r1, $urandom_range(15, 0) == 0);
      if ($urandom_range(599, 0) == 0) do_reset(int'($urandom_range(3, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 Parameter WIDTH, default 4, sample width; SHALL equal the width of the serial ADC reader's dout.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before a conversion is abandoned; legal range 2..255.
REQ-003 clock44kHz  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: asserts immediately when low, releases synchronously to clock44kHz.
REQ-005 req0  input  1  requester 0 sample request (level).
REQ-006 req1  input  1  requester 1 sample request (level).
REQ-007 adc_listo  input  1  conversion-complete pulse from the ADC reader.
REQ-008 adc_dout  input  WIDTH  conversion data from the ADC reader, valid while adc_listo is high.
REQ-009 adc_inicio  output  1  one-cycle conversion start pulse to the ADC reader.
REQ-010 sample  output  WIDTH  last captured conversion data.
REQ-011 valid0  output  1  one-cycle pulse: sample belongs to requester 0.
REQ-012 valid1  output  1  one-cycle pulse: sample belongs to requester 1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant  output  1  index of the requester currently or last served.
REQ-015 timeout_err  output  1  one-cycle pulse when a conversion is abandoned.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs SHALL be registered.
REQ-017 IDLE: no request -> stay; any request -> latch winner into grant, go START.
REQ-018 Arbitration SHALL be round-robin: a priority pointer selects the preferred requester; with only one requesting, it wins; with both, the pointer's requester wins.
REQ-019 Pointer SHALL move to the non-granted requester on completion (DONE) and on timeout.
REQ-020 START: adc_inicio SHALL be high for exactly this one cycle; WAIT counter cleared to 0; go WAIT.
REQ-021 WAIT: counter increments each cycle; adc_listo high -> capture adc_dout into sample, go DONE.
REQ-022 WAIT: counter reaching TIMEOUT-1 with adc_listo low -> timeout_err pulse, sample unchanged, no valid, go IDLE.
REQ-023 adc_listo and counter terminal value in the same cycle SHALL be treated as completion (listo wins).
REQ-024 DONE: valid<grant> high for this one cycle, the other valid low; go IDLE.
REQ-025 Latency from first IDLE cycle with a request to valid SHALL be 3 + N cycles, N = WAIT cycles until adc_listo.
REQ-026 adc_listo in IDLE, START or DONE SHALL be ignored (no capture, no valid).
REQ-027 Requests SHALL be sampled only in IDLE; req changes in other states SHALL have no effect.
REQ-028 A requester holding req high after its valid SHALL receive another conversion, subject to round-robin (streaming).
REQ-029 valid0 and valid1 SHALL never be high together; adc_inicio SHALL never be high outside START.

Reset
REQ-030 While reset is low: state IDLE, pointer = requester 0, grant 0, counter 0, sample 0, adc_inicio 0, valid0 0, valid1 0, busy 0, timeout_err 0.
REQ-031 Reset asserted mid-conversion SHALL abandon it without valid or timeout_err; a later adc_listo SHALL be ignored per REQ-026.

Verification
REQ-032 req0 held, ADC model returns 4'hA with listo 5 cycles after inicio -> one inicio pulse, valid0 on the cycle after listo, sample=4'hA, grant=0.
REQ-033 req0 and req1 both held continuously after reset -> grants alternate 0,1,0,1; valid pulses alternate; never simultaneous.
REQ-034 req1 only, ADC never asserts listo (TIMEOUT=15) -> timeout_err pulse 15 WAIT cycles after START, no valid1, sample unchanged, return to IDLE.
REQ-035 listo coincident with the terminal WAIT cycle -> capture and valid, no timeout_err.
REQ-036 Reset pulled low during WAIT, released, then a stray listo -> all outputs at reset values, no valid, no capture.
REQ-037 Spurious listo in IDLE with 4'h5 on adc_dout -> sample keeps previous value, no valid.
